// File: rtl/novacore_cfg_loader_pkg.sv
// Shared definitions for the NovaCORE configuration loader: FSM state
// encoding, payload word-count helper and header field offsets.
package novacore_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_DONE
    } state_e;

    // Header layout: uid at the bottom, dim directly above it, END flag in the MSB.
    localparam int unsigned UID_LSB = 0;

    function automatic int unsigned dim_lsb(input int unsigned uid_w);
        return uid_w;
    endfunction

    function automatic int unsigned end_bit(input int unsigned in_w);
        return in_w - 1;
    endfunction

    // Number of stream words that make up one frame payload.
    function automatic int unsigned calc_nw(input int unsigned bus_w, input int unsigned in_w);
        return (bus_w + in_w - 1) / in_w;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/novacore_cfg_loader_if.sv
// Valid/ready word stream from the bitstream source into the loader.
interface novacore_cfg_loader_if #(
    parameter int unsigned IN_W = 16
) ();
    logic [IN_W-1:0] s_data;
    logic            s_valid;
    logic            s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/novacore_cfg_loader_assembler.sv
// Collects the payload words of one frame, least-significant word first,
// and presents the assembled BUS_W payload together with the last word.
module novacore_cfg_assembler
    import novacore_cfg_pkg::*;
#(
    parameter int unsigned BUS_W = 82,
    parameter int unsigned IN_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             word_en,
    input  logic [IN_W-1:0]  word,
    output logic [BUS_W-1:0] payload,
    output logic             full
);

    localparam int unsigned NW        = calc_nw(BUS_W, IN_W);
    localparam int unsigned SR_W      = (NW > 1) ? (NW - 1) * IN_W : IN_W;
    localparam int unsigned LAST_BITS = BUS_W - (NW - 1) * IN_W;
    localparam int unsigned CNT_W     = $clog2(NW + 1);

    generate
        if (NW == 1) begin : g_single
            assign payload = word[BUS_W-1:0];
            assign full    = word_en;
        end else begin : g_multi
            // Only the first NW-1 words are stored; the final word is spliced in
            // combinationally so the frame can be registered on the edge it arrives.
            logic [SR_W-1:0]  sr;
            logic [CNT_W-1:0] cnt;

            assign full    = word_en && (cnt == CNT_W'(NW - 1));
            assign payload = {word[LAST_BITS-1:0], sr};

            // Word counter and shift register, cleared between frames.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    sr  <= '0;
                    cnt <= '0;
                end else if (word_en) begin
                    if (full) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (NW == 2) begin
                            sr <= word;
                        end else begin
                            sr <= {word, sr[SR_W-1:IN_W]};
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/novacore_cfg_loader.sv
// Transmit end of the NovaCORE configuration interface: turns a stream of
// header+payload frames into c_bus/c_uid/c_dimension/c_dimswitch updates with
// one c_clk strobe each, and switches to run mode on an END header.
module novacore_cfg_loader
    import novacore_cfg_pkg::*;
#(
    parameter int unsigned BUS_W  = 82,
    parameter int unsigned UID_W  = 9,
    parameter int unsigned DIM_W  = 2,
    parameter int unsigned IN_W   = 16,
    parameter int unsigned CLK_HI = 2,
    parameter int unsigned CLK_LO = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    novacore_cfg_loader_if.slave stream,
    output logic                 mode,
    output logic [BUS_W-1:0]     c_bus,
    output logic [UID_W-1:0]     c_uid,
    output logic                 c_clk,
    output logic [DIM_W-1:0]     c_dimension,
    output logic                 c_dimswitch,
    output logic [15:0]          frame_cnt
);

    localparam int unsigned DIM_LSB = dim_lsb(UID_W);
    localparam int unsigned END_BIT = end_bit(IN_W);
    localparam int unsigned PH_MAX  = max_u(CLK_HI, CLK_LO);
    localparam int unsigned PH_W    = $clog2(PH_MAX + 1);

    state_e           state;
    logic [PH_W-1:0]  phase;
    logic [UID_W-1:0] hdr_uid;
    logic [DIM_W-1:0] hdr_dim;
    logic [DIM_W-1:0] last_dim;
    logic             first_frame;
    logic             accept;
    logic             asm_full;
    logic [BUS_W-1:0] asm_payload;

    assign stream.s_ready = (state == ST_IDLE) || (state == ST_LOAD);
    assign accept         = stream.s_valid && stream.s_ready;

    novacore_cfg_assembler #(
        .BUS_W (BUS_W),
        .IN_W  (IN_W)
    ) u_assembler (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == ST_SETUP),
        .word_en (accept && (state == ST_LOAD)),
        .word    (stream.s_data),
        .payload (asm_payload),
        .full    (asm_full)
    );

    // Frame sequencer with registered fabric-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            phase       <= '0;
            hdr_uid     <= '0;
            hdr_dim     <= '0;
            last_dim    <= '0;
            first_frame <= 1'b1;
            mode        <= 1'b0;
            c_bus       <= '0;
            c_uid       <= '0;
            c_clk       <= 1'b0;
            c_dimension <= '0;
            c_dimswitch <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (stream.s_data[END_BIT]) begin
                            state       <= ST_DONE;
                            mode        <= 1'b1;
                            c_dimswitch <= 1'b0;
                        end else begin
                            hdr_uid <= stream.s_data[DIM_LSB-1:UID_LSB];
                            hdr_dim <= stream.s_data[DIM_LSB+DIM_W-1:DIM_LSB];
                            state   <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (asm_full) begin
                        c_bus       <= asm_payload;
                        c_uid       <= hdr_uid;
                        c_dimension <= hdr_dim;
                        c_dimswitch <= first_frame || (hdr_dim != last_dim);
                        last_dim    <= hdr_dim;
                        first_frame <= 1'b0;
                        state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    c_clk     <= 1'b1;
                    phase     <= PH_W'(CLK_HI - 1);
                    frame_cnt <= frame_cnt + 16'd1;
                    state     <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (phase == '0) begin
                        c_clk <= 1'b0;
                        phase <= PH_W'(CLK_LO - 1);
                        state <= ST_LOW;
                    end else begin
                        phase <= phase - PH_W'(1);
                    end
                end
                ST_LOW: begin
                    if (phase == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        phase <= phase - PH_W'(1);
                    end
                end
                ST_DONE: begin
                    if (cfg_start) begin
                        mode        <= 1'b0;
                        frame_cnt   <= '0;
                        first_frame <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_novacore_cfg_loader.sv
// Self-checking bench for novacore_cfg_loader: table of frames driven through
// the stream interface, expected strobes queued at drive time and checked as
// c_clk rises, plus hand sequences for END/cfg_start and mid-strobe reset.
module tb_novacore_cfg_loader;

    typedef struct {
        logic [15:0]       hdr;
        logic [5:0][15:0]  w;
        int                gap;
        logic [8:0]        uid;
        logic [1:0]        dim;
        logic [81:0]       bus;
        logic              ds;
        logic [15:0]       cnt;
    } frame_t;

    typedef struct {
        logic [8:0]  uid;
        logic [1:0]  dim;
        logic [81:0] bus;
        logic        ds;
        logic [15:0] cnt;
        int          rise;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic        mode;
    logic [81:0] c_bus;
    logic [8:0]  c_uid;
    logic        c_clk;
    logic [1:0]  c_dimension;
    logic        c_dimswitch;
    logic [15:0] frame_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_p = 0;
    bit mon_en = 1'b0;
    bit ignore_width = 1'b0;
    exp_t exp_q[$];
    frame_t frames[5];

    novacore_cfg_loader_if #(.IN_W(16)) s_bus ();

    novacore_cfg_loader #(
        .BUS_W  (82),
        .UID_W  (9),
        .DIM_W  (2),
        .IN_W   (16),
        .CLK_HI (2),
        .CLK_LO (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .stream      (s_bus),
        .mode        (mode),
        .c_bus       (c_bus),
        .c_uid       (c_uid),
        .c_clk       (c_clk),
        .c_dimension (c_dimension),
        .c_dimswitch (c_dimswitch),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic frame_t mk(input logic [15:0] hdr, input logic [5:0][15:0] w, input int gap,
                                  input logic [8:0] uid, input logic [1:0] dim, input logic [81:0] bus,
                                  input logic ds, input logic [15:0] cnt);
        frame_t f;
        f.hdr = hdr; f.w = w; f.gap = gap; f.uid = uid; f.dim = dim;
        f.bus = bus; f.ds = ds; f.cnt = cnt;
        return f;
    endfunction

    // Called at a negedge; returns at the negedge after acceptance with s_valid low.
    task automatic send_word(input logic [15:0] w, output int acc);
        int n = 0;
        s_bus.s_data  = w;
        s_bus.s_valid = 1'b1;
        while (!s_bus.s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_bus.s_ready) begin
            check("accept_timeout", 1'b0, 1'b1);
            acc = -1;
            s_bus.s_valid = 1'b0;
        end else begin
            acc = cyc;
            @(posedge clk);
            @(negedge clk);
            s_bus.s_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input frame_t f, input bit chk_period);
        int h;
        int p;
        exp_t e;
        send_word(f.hdr, h);
        if (chk_period) check("hdr_accept_cycle", h, last_p + 6);
        p = 0;
        for (int i = 0; i < 6; i++) begin
            if (f.gap > 0) repeat (f.gap) @(negedge clk);
            send_word(f.w[i], p);
        end
        e.uid = f.uid; e.dim = f.dim; e.bus = f.bus; e.ds = f.ds; e.cnt = f.cnt; e.rise = p + 2;
        exp_q.push_back(e);
        last_p = p;
        check("setup_c_bus", c_bus, f.bus);
        check("setup_c_clk", c_clk, 1'b0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("strobe_pending", exp_q.size(), 0);
    endtask

    // Strobe monitor: pops the expected frame on each c_clk rise and checks width on fall.
    int high_len = 0;
    logic prev_cclk = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (c_clk && !prev_cclk) begin
                high_len = 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("rise_cycle", cyc, e.rise);
                    check("c_uid", c_uid, e.uid);
                    check("c_dimension", c_dimension, e.dim);
                    check("c_bus", c_bus, e.bus);
                    check("c_dimswitch", c_dimswitch, e.ds);
                    check("frame_cnt", frame_cnt, e.cnt);
                    check("s_ready_in_strobe", s_bus.s_ready, 1'b0);
                end
            end else if (c_clk) begin
                high_len++;
            end else if (prev_cclk && !ignore_width) begin
                check("c_clk_high_len", high_len, 2);
            end
        end
        prev_cclk = c_clk;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        frames[0] = mk(16'h0305, {16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111}, 0,
                       9'h105, 2'b01, {2'b10, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1'b1, 16'd1);
        frames[1] = mk(16'h02AA, {16'hA006, 16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001}, 0,
                       9'h0AA, 2'b01, {2'b10, 16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001}, 1'b0, 16'd2);
        frames[2] = mk(16'h0405, {16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001}, 0,
                       9'h005, 2'b10, {2'b10, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b1, 16'd3);
        frames[3] = mk(16'h0305, {16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111}, 3,
                       9'h105, 2'b01, {2'b10, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1'b1, 16'd4);
        frames[4] = mk(16'h07FF, {16'hFFFD, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 0,
                       9'h1FF, 2'b11, {2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 1'b1, 16'd5);

        s_bus.s_data  = '0;
        s_bus.s_valid = 1'b0;

        // Reset held two cycles.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_mode", mode, 1'b0);
        check("rst_c_clk", c_clk, 1'b0);
        check("rst_c_bus", c_bus, 82'd0);
        check("rst_frame_cnt", frame_cnt, 16'd0);
        check("rst_s_ready", s_bus.s_ready, 1'b1);
        mon_en = 1'b1;

        // cfg_start outside DONE has no effect.
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("idle_cfg_start_mode", mode, 1'b0);
        check("idle_cfg_start_ready", s_bus.s_ready, 1'b1);

        // Table of frames, back to back where the DUT allows.
        for (int i = 0; i < 5; i++) send_frame(frames[i], i > 0);
        wait_drain();

        // END header.
        begin
            int e_acc;
            send_word(16'h8000, e_acc);
            check("end_accept_cycle", e_acc, last_p + 6);
            check("end_mode", mode, 1'b1);
            check("end_s_ready", s_bus.s_ready, 1'b0);
            check("end_dimswitch", c_dimswitch, 1'b0);
            check("end_frame_cnt", frame_cnt, 16'd5);
            // Words offered in DONE must be refused.
            s_bus.s_data  = 16'h0305;
            s_bus.s_valid = 1'b1;
            repeat (3) @(negedge clk);
            check("done_s_ready", s_bus.s_ready, 1'b0);
            check("done_c_clk", c_clk, 1'b0);
            s_bus.s_valid = 1'b0;
            cfg_start = 1'b1;
            @(negedge clk);
            cfg_start = 1'b0;
            check("cfg_start_mode", mode, 1'b0);
            check("cfg_start_frame_cnt", frame_cnt, 16'd0);
            check("cfg_start_s_ready", s_bus.s_ready, 1'b1);
        end

        // First frame after cfg_start flags a dimension switch even with the same dim.
        send_frame(mk(16'h07FF, frames[4].w, 0, 9'h1FF, 2'b11, frames[4].bus, 1'b1, 16'd1), 1'b0);
        send_frame(mk(16'h07FF, frames[4].w, 0, 9'h1FF, 2'b11, frames[4].bus, 1'b0, 16'd2), 1'b1);

        // Reset in the middle of the high phase.
        begin
            int n = 0;
            while (!c_clk && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("reach_high", c_clk, 1'b1);
            ignore_width = 1'b1;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("midrst_c_clk", c_clk, 1'b0);
            check("midrst_mode", mode, 1'b0);
            check("midrst_c_bus", c_bus, 82'd0);
            check("midrst_frame_cnt", frame_cnt, 16'd0);
            check("midrst_dimswitch", c_dimswitch, 1'b0);
            check("midrst_s_ready", s_bus.s_ready, 1'b1);
            @(negedge clk);
            ignore_width = 1'b0;
        end

        send_frame(mk(16'h0001, {16'h0106, 16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0101}, 0,
                      9'h001, 2'b00, {2'b10, 16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0101},
                      1'b1, 16'd1), 1'b0);
        wait_drain();
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
